// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Converter control states; there is no separate done state.
  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned BCD_W      = 4;

  // Nibbles at or above this value get +3 before each shift.
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Per-nibble double-dabble correction: adds 3 when the digit is >= 5.
// Four bits in, four bits out, carry-free.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nib,
  output logic [BCD_W-1:0] o_nib
);

  assign o_nib = (i_nib >= ADD3_THRESH) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digit outputs update only when a conversion completes, so the downstream
// digit mux never sees intermediate values.
// Optional macro BIN2BCD_AUTO_START_EN: ignore start and launch a conversion
// whenever bin differs from the last converted value while idle.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundos
);

  localparam int unsigned SW = WIDTH + BCD_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e            r_state, w_state_nxt;
  logic [SW-1:0]     r_scratch, w_scratch_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_done, w_done_nxt;
  logic [3:0]        r_ones, w_ones_nxt;
  logic [3:0]        r_tens, w_tens_nxt;
  logic [3:0]        r_hundos, w_hundos_nxt;
  logic [SW-1:0]     w_corr;
  logic [SW-1:0]     w_shift;
  logic              w_launch;

  // Correct every BCD nibble, pass the binary part through, then shift.
  assign w_corr[WIDTH-1:0] = r_scratch[WIDTH-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib(r_scratch[WIDTH + g*BCD_W +: BCD_W]),
      .o_nib(w_corr[WIDTH + g*BCD_W +: BCD_W])
    );
  end
  assign w_shift = {w_corr[SW-2:0], 1'b0};

`ifdef BIN2BCD_AUTO_START_EN
  logic [WIDTH-1:0] r_last, w_last_nxt;
  // start is deliberately ignored in this build; the term is constant-false.
  assign w_launch = (bin != r_last) || (start && 1'b0);
`else
  assign w_launch = start;
`endif

  // Next-state, datapath and output-register logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_scratch_nxt = r_scratch;
    w_count_nxt   = r_count;
    w_done_nxt    = 1'b0;
    w_ones_nxt    = r_ones;
    w_tens_nxt    = r_tens;
    w_hundos_nxt  = r_hundos;
`ifdef BIN2BCD_AUTO_START_EN
    w_last_nxt    = r_last;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_launch) begin
          w_scratch_nxt = {{(BCD_W*DIGITS){1'b0}}, bin};
          w_count_nxt   = CW'(WIDTH);
          w_state_nxt   = StShift;
`ifdef BIN2BCD_AUTO_START_EN
          w_last_nxt    = bin;
`endif
        end
      end
      StShift: begin
        w_scratch_nxt = w_shift;
        w_count_nxt   = r_count - CW'(1);
        // Last shift: publish digits from the freshly shifted value.
        if (r_count == CW'(1)) begin
          w_state_nxt  = StIdle;
          w_done_nxt   = 1'b1;
          w_ones_nxt   = w_shift[WIDTH +: 4];
          w_tens_nxt   = w_shift[WIDTH + 4 +: 4];
          w_hundos_nxt = w_shift[WIDTH + 8 +: 4];
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_hundos  <= 4'd0;
    end else begin
      r_scratch <= w_scratch_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_ones    <= w_ones_nxt;
      r_tens    <= w_tens_nxt;
      r_hundos  <= w_hundos_nxt;
    end
  end

`ifdef BIN2BCD_AUTO_START_EN
  // Last launched value; reset to 0 so bin=0 alone triggers nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else begin
      r_last <= w_last_nxt;
    end
  end
`endif

  assign busy   = (r_state == StShift);
  assign done   = r_done;
  assign ones   = r_ones;
  assign tens   = r_tens;
  assign hundos = r_hundos;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a tracker process models acceptance and
// handshake timing and queues expected digits; a monitor checks every cycle.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin = 8'd0;
  logic       busy, done;
  logic [3:0] ones, tens, hundos;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  int          rem = 0;          // model: shifts remaining
  bit          exp_done = 1'b0;
  logic [7:0]  last = 8'd0;      // model: last launched value (auto mode)
  logic [11:0] held = 12'd0;     // model: digits currently shown

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ones  (ones),
    .tens  (tens),
    .hundos(hundos)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Tracker: decides from the bench's own view when a conversion launches.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      rem = 0;
      exp_done = 1'b0;
      held = 12'd0;
      last = 8'd0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) exp_done = 1'b1;
      end else begin
`ifdef BIN2BCD_AUTO_START_EN
        if (bin != last) begin
`else
        if (start) begin
`endif
          exp_q.push_back(ref_bcd(int'(bin)));
          last = bin;
          rem = 8;
        end
      end
    end
  end

  // Monitor: compares handshake and digits away from the rising edge.
  initial forever begin
    @(negedge clk);
    chk("busy", {11'd0, busy}, {11'd0, rem > 0});
    chk("done", {11'd0, done}, {11'd0, exp_done});
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: got empty queue required one entry at %0t", $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("digits", {hundos, tens, ones}, held);
  end

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    #2;
    start = 1'b1;
    bin = b;
    @(negedge clk);
    #2;
    start = 1'b0;
    bin = 8'($urandom);
  endtask

  task automatic set_bin(input logic [7:0] b, input int hold);
    @(negedge clk);
    #2;
    bin = b;
    repeat (hold) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
`ifdef BIN2BCD_AUTO_START_EN
    set_bin(8'd0, 10);
    set_bin(8'd42, 10);
    set_bin(8'd42, 10);
    set_bin(8'd7, 10);
    set_bin(8'd200, 4);
    pulse_reset();
    repeat (12) @(negedge clk);
    set_bin(8'd255, 10);
    repeat (30) set_bin(8'($urandom), $urandom_range(3, 12));
`else
    pulse_start(8'd0);
    repeat (10) @(negedge clk);
    pulse_start(8'd255);
    repeat (10) @(negedge clk);
    // Re-pulse while busy is ignored.
    pulse_start(8'd100);
    pulse_start(8'd37);
    repeat (12) @(negedge clk);
    // Start in the done cycle of the previous conversion.
    pulse_start(8'd9);
    repeat (7) @(negedge clk);
    pulse_start(8'd128);
    repeat (10) @(negedge clk);
    // Reset partway through a conversion.
    pulse_start(8'd200);
    repeat (2) @(negedge clk);
    pulse_reset();
    repeat (3) @(negedge clk);
    pulse_start(8'd200);
    repeat (10) @(negedge clk);
    foreach (exp_q[i]) begin end
    for (int k = 0; k < 6; k++) begin
      logic [7:0] edges[6] = '{8'd1, 8'd10, 8'd99, 8'd199, 8'd254, 8'd250};
      pulse_start(edges[k]);
      repeat (9) @(negedge clk);
    end
    repeat (40) begin
      pulse_start(8'($urandom));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
`endif
    repeat (14) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
